// File: rtl/serv_pc_pkg.sv
// Shared definitions for the serial PC unit: fetch FSM states and PC increments.
package serv_pc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UPDATE = 2'd1,
      ST_FETCH  = 2'd2
   } pc_state_e;

   localparam logic [31:0] PC_INC4 = 32'd4;
   localparam logic [31:0] PC_INC2 = 32'd2;

endpackage

// File: rtl/serv_ser_add_w.sv
// W-bit serial adder slice; the carry ripples between beats through carry_q.
module serv_ser_add_w #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic [W-1:0] o_q
);

   logic         carry_q;
   logic         carry_d;
   logic [W:0]   sum;

   assign sum     = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, carry_q};
   assign o_q     = sum[W-1:0];
   assign carry_d = i_clr ? 1'b0 : sum[W];

   always_ff @(posedge clk) begin
      if (i_rst) carry_q <= 1'b0;
      else       carry_q <= carry_d;
   end

endmodule

// File: rtl/serv_pc_unit.sv
// Bit-serial program counter: shifts in PC+4/PC+2, a jump target or the trap
// vector W bits per beat, then issues an instruction fetch of the new PC.
module serv_pc_unit
   import serv_pc_pkg::*;
#(
   parameter int          W          = 1,
   parameter logic [31:0] RESET_PC   = 32'd8,
   parameter int          COMPRESSED = 0
) (
   input  logic         clk,
   input  logic         i_rst,
   input  logic         i_en,
   input  logic         i_pc_en,
   input  logic         i_cnt_done,
   input  logic         i_jump,
   input  logic [W-1:0] i_offset,
   input  logic [W-1:0] i_rs1,
   input  logic         i_jalr,
   input  logic         i_jal_or_jalr,
   input  logic         i_utype,
   input  logic         i_lui,
   input  logic         i_trap,
   input  logic [W-1:0] i_csr_pc,
   input  logic         i_iscomp,
   output logic [W-1:0] o_rd,
   output logic [W-1:0] o_bad_pc,
   output logic         o_misalign,
   output logic [31:0]  o_ibus_adr,
   output logic         o_ibus_cyc,
   input  logic         i_ibus_ack
);

   // Target bit 1 appears on beat 1 for a 1-bit datapath, otherwise on beat 0.
   localparam logic [4:0] MIS_BEAT = (W == 1) ? 5'd1 : 5'd0;
   localparam int         MIS_BIT  = (W == 1) ? 0 : 1;

   pc_state_e    state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [4:0]   cnt_q, cnt_d;
   logic         cyc_q;
   logic         mis_q;
   logic         shift_en;
   logic         first_beat;
   logic [31:0]  inc_word, inc_sh;
   logic [W-1:0] inc_bits, seq_bits, offset_a, tgt, tgt_al, csr_al, new_bits;

   // A pending fetch freezes the PC so the bus address is stable until ack.
   assign shift_en   = i_pc_en & (state_q != ST_FETCH);
   assign first_beat = (cnt_q == 5'd0);

   assign inc_word = ((COMPRESSED != 0) && i_iscomp) ? PC_INC2 : PC_INC4;
   assign inc_sh   = inc_word >> (32'(cnt_q) * 32'(W));
   assign inc_bits = inc_sh[W-1:0];
   assign offset_a = i_lui ? '0 : (i_jalr ? i_rs1 : pc_q[W-1:0]);

   serv_ser_add_w #(.W(W)) u_seq_add (
      .clk   (clk),
      .i_rst (i_rst),
      .i_clr (i_cnt_done | ~shift_en),
      .i_a   (pc_q[W-1:0]),
      .i_b   (inc_bits),
      .o_q   (seq_bits)
   );

   serv_ser_add_w #(.W(W)) u_tgt_add (
      .clk   (clk),
      .i_rst (i_rst),
      .i_clr (~i_en | (i_cnt_done & ~i_pc_en)),
      .i_a   (offset_a),
      .i_b   (i_offset),
      .o_q   (tgt)
   );

   assign tgt_al   = tgt & ~W'(first_beat);
   assign csr_al   = i_csr_pc & ~W'(first_beat);
   assign new_bits = i_trap ? csr_al : (i_jump ? tgt_al : seq_bits);

   assign pc_d  = shift_en ? {new_bits, pc_q[31:W]} : pc_q;
   assign cnt_d = i_cnt_done ? 5'd0 : (shift_en ? cnt_q + 5'd1 : cnt_q);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (i_pc_en)    state_d = ST_UPDATE;
         ST_UPDATE: if (!i_pc_en)   state_d = ST_FETCH;
         ST_FETCH:  if (i_ibus_ack) state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   // Reset parks the FSM in UPDATE so the boot fetch follows one cycle later.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= ST_UPDATE;
         pc_q    <= RESET_PC;
         cnt_q   <= 5'd0;
         cyc_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         cyc_q   <= (state_d == ST_FETCH);
         if ((COMPRESSED == 0) && shift_en && (cnt_q == MIS_BEAT))
            mis_q <= tgt[MIS_BIT];
      end
   end

   assign o_rd       = ({W{i_utype}} & tgt_al) | ({W{i_jal_or_jalr}} & seq_bits);
   assign o_bad_pc   = tgt_al;
   assign o_misalign = mis_q;
   assign o_ibus_adr = pc_q;
   assign o_ibus_cyc = cyc_q;

endmodule

// File: tb/tb_serv_pc_unit.sv
// Directed bench for serv_pc_unit: four instances (W=4, W=4 compressed, W=1, W=8).
module tb_serv_pc_unit;

   logic clk, rst, ack;
   logic en, pc_en, cnt_done;
   logic jump, jalr, jal_or_jalr, utype, lui, trap, iscomp;
   logic [31:0] off_w, rs1_w, csr_w;
   int beat, sel;
   int checks, errors;

   logic [3:0] rd0, bad0, rd1, bad1;
   logic [0:0] rd2, bad2;
   logic [7:0] rd3, bad3;
   logic [31:0] adr0, adr1, adr2, adr3;
   logic cyc0, cyc1, cyc2, cyc3, mis0, mis1, mis2, mis3;

   logic [7:0]  rd_s, bad_s;
   logic [31:0] adr_s;
   logic        cyc_s, mis_s;
   logic [31:0] rd_acc, bad_acc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   serv_pc_unit #(.W(4), .RESET_PC(32'h8), .COMPRESSED(0)) u0 (
      .clk(clk), .i_rst(rst), .i_en(en & (sel == 0)), .i_pc_en(pc_en & (sel == 0)),
      .i_cnt_done(cnt_done & (sel == 0)), .i_jump(jump), .i_offset(4'(off_w >> (beat * 4))),
      .i_rs1(4'(rs1_w >> (beat * 4))), .i_jalr(jalr), .i_jal_or_jalr(jal_or_jalr),
      .i_utype(utype), .i_lui(lui), .i_trap(trap), .i_csr_pc(4'(csr_w >> (beat * 4))),
      .i_iscomp(iscomp), .o_rd(rd0), .o_bad_pc(bad0), .o_misalign(mis0),
      .o_ibus_adr(adr0), .o_ibus_cyc(cyc0), .i_ibus_ack(ack));

   serv_pc_unit #(.W(4), .RESET_PC(32'h8), .COMPRESSED(1)) u1 (
      .clk(clk), .i_rst(rst), .i_en(en & (sel == 1)), .i_pc_en(pc_en & (sel == 1)),
      .i_cnt_done(cnt_done & (sel == 1)), .i_jump(jump), .i_offset(4'(off_w >> (beat * 4))),
      .i_rs1(4'(rs1_w >> (beat * 4))), .i_jalr(jalr), .i_jal_or_jalr(jal_or_jalr),
      .i_utype(utype), .i_lui(lui), .i_trap(trap), .i_csr_pc(4'(csr_w >> (beat * 4))),
      .i_iscomp(iscomp), .o_rd(rd1), .o_bad_pc(bad1), .o_misalign(mis1),
      .o_ibus_adr(adr1), .o_ibus_cyc(cyc1), .i_ibus_ack(ack));

   serv_pc_unit #(.W(1), .RESET_PC(32'h8), .COMPRESSED(0)) u2 (
      .clk(clk), .i_rst(rst), .i_en(en & (sel == 2)), .i_pc_en(pc_en & (sel == 2)),
      .i_cnt_done(cnt_done & (sel == 2)), .i_jump(jump), .i_offset(1'(off_w >> beat)),
      .i_rs1(1'(rs1_w >> beat)), .i_jalr(jalr), .i_jal_or_jalr(jal_or_jalr),
      .i_utype(utype), .i_lui(lui), .i_trap(trap), .i_csr_pc(1'(csr_w >> beat)),
      .i_iscomp(iscomp), .o_rd(rd2), .o_bad_pc(bad2), .o_misalign(mis2),
      .o_ibus_adr(adr2), .o_ibus_cyc(cyc2), .i_ibus_ack(ack));

   serv_pc_unit #(.W(8), .RESET_PC(32'h8), .COMPRESSED(0)) u3 (
      .clk(clk), .i_rst(rst), .i_en(en & (sel == 3)), .i_pc_en(pc_en & (sel == 3)),
      .i_cnt_done(cnt_done & (sel == 3)), .i_jump(jump), .i_offset(8'(off_w >> (beat * 8))),
      .i_rs1(8'(rs1_w >> (beat * 8))), .i_jalr(jalr), .i_jal_or_jalr(jal_or_jalr),
      .i_utype(utype), .i_lui(lui), .i_trap(trap), .i_csr_pc(8'(csr_w >> (beat * 8))),
      .i_iscomp(iscomp), .o_rd(rd3), .o_bad_pc(bad3), .o_misalign(mis3),
      .o_ibus_adr(adr3), .o_ibus_cyc(cyc3), .i_ibus_ack(ack));

   always_comb begin
      rd_s = '0; bad_s = '0; adr_s = '0; cyc_s = 1'b0; mis_s = 1'b0;
      case (sel)
         0: begin rd_s = 8'(rd0); bad_s = 8'(bad0); adr_s = adr0; cyc_s = cyc0; mis_s = mis0; end
         1: begin rd_s = 8'(rd1); bad_s = 8'(bad1); adr_s = adr1; cyc_s = cyc1; mis_s = mis1; end
         2: begin rd_s = 8'(rd2); bad_s = 8'(bad2); adr_s = adr2; cyc_s = cyc2; mis_s = mis2; end
         default: begin rd_s = rd3; bad_s = bad3; adr_s = adr3; cyc_s = cyc3; mis_s = mis3; end
      endcase
   end

   function automatic int wof(input int k);
      case (k)
         2:       return 1;
         3:       return 8;
         default: return 4;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clr_flags();
      jump = 0; jalr = 0; jal_or_jalr = 0; utype = 0; lui = 0; trap = 0; iscomp = 0;
      off_w = '0; rs1_w = '0; csr_w = '0;
   endtask

   // One full update phase on the selected instance, then the fetch handshake.
   task automatic run_op();
      int w, n;
      w = wof(sel);
      n = 32 / w;
      rd_acc = '0; bad_acc = '0;
      for (int b = 0; b < n; b++) begin
         beat = b; en = 1; pc_en = 1; cnt_done = (b == n - 1);
         #2;
         rd_acc  = rd_acc  | (32'(rd_s)  << (b * w));
         bad_acc = bad_acc | (32'(bad_s) << (b * w));
         @(posedge clk); #1;
      end
      en = 0; pc_en = 0; cnt_done = 0; beat = 0;
      chk("lat_early", 32'(cyc_s), 32'd0);
      @(posedge clk); #1;
      chk("lat_cyc", 32'(cyc_s), 32'd1);
      ack = 1; @(posedge clk); #1; ack = 0;
      chk("ack_drop", 32'(cyc_s), 32'd0);
   endtask

   task automatic load_pc(input logic [31:0] v);
      clr_flags(); lui = 1; jump = 1; off_w = v;
      run_op();
      clr_flags();
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1; ack = 0; en = 0; pc_en = 0; cnt_done = 0; beat = 0; sel = 0;
      clr_flags();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cyc", 32'(cyc_s), 32'd0);
      chk("rst_adr", adr_s, 32'h8);
      chk("rst_mis", 32'(mis_s), 32'd0);
      rst = 0; @(posedge clk); #1;
      chk("boot_cyc", 32'(cyc_s), 32'd1);
      chk("boot_adr", adr_s, 32'h8);
      ack = 1; @(posedge clk); #1; ack = 0;
      chk("boot_ack", 32'(cyc_s), 32'd0);

      // sequential increments
      sel = 0; load_pc(32'h10); chk("load10", adr_s, 32'h10);
      run_op(); chk("seq4", adr_s, 32'h14);
      iscomp = 1; run_op(); iscomp = 0; chk("seq_nocomp", adr_s, 32'h18);
      sel = 1; load_pc(32'h10);
      iscomp = 1; run_op(); iscomp = 0; chk("seq2", adr_s, 32'h12);

      // jal on W=1 and W=8, auipc on W=8
      for (int k = 2; k < 4; k++) begin
         sel = k; load_pc(32'h10);
         jump = 1; jal_or_jalr = 1; off_w = 32'h100;
         run_op(); clr_flags();
         chk("jal_adr", adr_s, 32'h110);
         chk("jal_rd", rd_acc, 32'h14);
      end
      utype = 1; off_w = 32'h1000; run_op(); clr_flags();
      chk("auipc_rd", rd_acc, 32'h1110);
      chk("auipc_adr", adr_s, 32'h114);

      // jalr to an odd, 2-aligned address
      sel = 0; jump = 1; jalr = 1; jal_or_jalr = 1; rs1_w = 32'h23;
      run_op();
      chk("jalr_adr", adr_s, 32'h22);
      chk("jalr_bad", bad_acc, 32'h22);
      chk("jalr_rd", rd_acc, 32'h1C);
      chk("jalr_mis", 32'(mis_s), 32'd1);
      sel = 1; run_op();
      chk("jalr_c_adr", adr_s, 32'h22);
      chk("jalr_c_mis", 32'(mis_s), 32'd0);
      sel = 2; run_op(); clr_flags();
      chk("jalr_w1_adr", adr_s, 32'h22);
      chk("jalr_w1_mis", 32'(mis_s), 32'd1);

      // trap wins over jump; wrap-around of the increment
      sel = 0; trap = 1; csr_w = 32'h81; jump = 1; lui = 1; off_w = 32'h40;
      run_op(); clr_flags();
      chk("trap_adr", adr_s, 32'h80);
      load_pc(32'hFFFFFFFC);
      run_op(); chk("wrap", adr_s, 32'h0);

      // reset mid-UPDATE
      lui = 1; jump = 1; off_w = 32'h55550; en = 1; pc_en = 1;
      for (int b = 0; b < 3; b++) begin beat = b; @(posedge clk); #1; end
      rst = 1; en = 0; pc_en = 0; beat = 0; clr_flags();
      @(posedge clk); #1;
      chk("rst_upd_adr", adr_s, 32'h8);
      chk("rst_upd_cyc", 32'(cyc_s), 32'd0);
      rst = 0; @(posedge clk); #1;
      chk("reboot_cyc", 32'(cyc_s), 32'd1);

      // pc_en while fetching must not move the address
      lui = 1; jump = 1; off_w = 32'h1000; en = 1; pc_en = 1;
      for (int b = 0; b < 4; b++) begin beat = b; @(posedge clk); #1; end
      en = 0; pc_en = 0; beat = 0; clr_flags();
      chk("fetch_hold_adr", adr_s, 32'h8);
      chk("fetch_hold_cyc", 32'(cyc_s), 32'd1);

      // reset mid-FETCH, then a stray ack while idle
      rst = 1; @(posedge clk); #1;
      chk("rst_fetch_cyc", 32'(cyc_s), 32'd0);
      chk("rst_fetch_adr", adr_s, 32'h8);
      rst = 0; @(posedge clk); #1;
      chk("reboot2_cyc", 32'(cyc_s), 32'd1);
      ack = 1; @(posedge clk); #1; ack = 0;
      chk("reboot2_ack", 32'(cyc_s), 32'd0);
      ack = 1; @(posedge clk); #1; ack = 0; @(posedge clk); #1;
      chk("idle_ack_cyc", 32'(cyc_s), 32'd0);
      chk("idle_ack_adr", adr_s, 32'h8);
      run_op(); chk("post_rst_seq", adr_s, 32'hC);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
